// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM state type and op-code helpers for the MEM stage.
// Optional misaligned-access trap is controlled by MISALIGN_TRAP_EN.
package mem_stage_pkg;

  localparam int XLEN   = 32;
  localparam int RAM_AW = 17;

  localparam logic [3:0] MemOpNone = 4'd0;
  localparam logic [3:0] MemOpLB   = 4'd1;
  localparam logic [3:0] MemOpLH   = 4'd2;
  localparam logic [3:0] MemOpLW   = 4'd3;
  localparam logic [3:0] MemOpLBU  = 4'd4;
  localparam logic [3:0] MemOpLHU  = 4'd5;
  localparam logic [3:0] MemOpSB   = 4'd6;
  localparam logic [3:0] MemOpSH   = 4'd7;
  localparam logic [3:0] MemOpSW   = 4'd8;

  localparam logic [1:0] HaltNone   = 2'b00;
  localparam logic [1:0] HaltBubble = 2'b11;

  localparam logic [4:0]      NOPRegAddr = 5'd0;
  localparam logic [XLEN-1:0] ZeroWord   = '0;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // Codes 9..15 fall outside the range and behave like MemOpNone.
  function automatic logic isMemOp(input logic [3:0] op);
    return (op >= MemOpLB) && (op <= MemOpSW);
  endfunction

  function automatic logic isStore(input logic [3:0] op);
    return (op >= MemOpSB) && (op <= MemOpSW);
  endfunction

  function automatic logic [2:0] byteCount(input logic [3:0] op);
    case (op)
      MemOpLB, MemOpLBU, MemOpSB: return 3'd1;
      MemOpLH, MemOpLHU, MemOpSH: return 3'd2;
      MemOpLW, MemOpSW:           return 3'd4;
      default:                    return 3'd0;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [3:0] op, input logic [1:0] addrLo);
    case (op)
      MemOpLH, MemOpLHU, MemOpSH: return addrLo[0];
      MemOpLW, MemOpSW:           return addrLo != 2'b00;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of EX/MEM inputs, byte-RAM port and MEM/WB outputs of the MEM stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [4:0]        ex_wd;
  logic              ex_wreg;
  logic [XLEN-1:0]   ex_wdata;
  logic [3:0]        ex_mem_op;
  logic [XLEN-1:0]   ex_mem_addr;
  logic [XLEN-1:0]   ex_store_data;
  logic [7:0]        ram_din;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [4:0]        mem_wd;
  logic              mem_wreg;
  logic [XLEN-1:0]   mem_wdata;
  logic [1:0]        halt_type;
  logic              stall_req;

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_mem_op, ex_mem_addr, ex_store_data, ram_din,
    output ram_addr, ram_wr, ram_dout, mem_wd, mem_wreg, mem_wdata, halt_type, stall_req
  );

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_mem_op, ex_mem_addr, ex_store_data, ram_din,
    input  ram_addr, ram_wr, ram_dout, mem_wd, mem_wreg, mem_wdata, halt_type, stall_req
  );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of the assembled little-endian load bytes to XLEN.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0]     data_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (op_i)
      MemOpLB:  result_o = {{24{data_i[7]}}, data_i[7:0]};
      MemOpLBU: result_o = {24'd0, data_i[7:0]};
      MemOpLH:  result_o = {{16{data_i[15]}}, data_i[15:0]};
      MemOpLHU: result_o = {16'd0, data_i[15:0]};
      default:  result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: multi-cycle byte-serial loads/stores, bubble + stall while busy.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses (adds port misalign).
module mem_stage
  import mem_stage_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [3:0]        op_q;
  logic [RAM_AW-1:0] addr_q;
  logic [XLEN-1:0]   sdata_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic [31:0]       data_q;
`ifdef MISALIGN_TRAP_EN
  logic              misalign_q;
`endif

  logic [2:0]        nBytes;
  logic [2:0]        capIdx;
  logic [RAM_AW-1:0] curAddr;
  logic [XLEN-1:0]   loadResult;

  assign nBytes  = byteCount(op_q);
  assign capIdx  = idx_q - 3'd1;
  assign curAddr = addr_q + RAM_AW'(idx_q);

  mem_stage_load_extend u_load_extend (
    .data_i   (data_q),
    .op_i     (op_q),
    .result_o (loadResult)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      op_q    <= MemOpNone;
      addr_q  <= '0;
      sdata_q <= ZeroWord;
      wd_q    <= NOPRegAddr;
      wreg_q  <= 1'b0;
      data_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (isMemOp(bus.ex_mem_op)) begin
            op_q    <= bus.ex_mem_op;
            addr_q  <= bus.ex_mem_addr[RAM_AW-1:0];
            sdata_q <= bus.ex_store_data;
            wd_q    <= bus.ex_wd;
            wreg_q  <= bus.ex_wreg;
            idx_q   <= 3'd0;
            data_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            if (isMisaligned(bus.ex_mem_op, bus.ex_mem_addr[1:0])) begin
              state_q    <= StDone;
              misalign_q <= 1'b1;
            end else begin
              state_q    <= StAccess;
              misalign_q <= 1'b0;
            end
`else
            state_q <= StAccess;
`endif
          end
        end
        StAccess: begin
          if (isStore(op_q)) begin
            if (idx_q == nBytes - 3'd1) state_q <= StDone;
            else                        idx_q   <= idx_q + 3'd1;
          end else begin
            // RAM returns a byte one cycle after its address, so capture lags issue by one.
            if (idx_q != 3'd0) data_q[{capIdx[1:0], 3'b000} +: 8] <= bus.ram_din;
            if (idx_q == nBytes) state_q <= StDone;
            else                 idx_q   <= idx_q + 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          idx_q   <= 3'd0;
`ifdef MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [RAM_AW-1:0] ramAddr;
  logic              ramWr;
  logic [7:0]        ramDout;
  logic [4:0]        memWd;
  logic              memWreg;
  logic [XLEN-1:0]   memWdata;
  logic [1:0]        haltType;
  logic              stallReq;

  always_comb begin
    ramAddr  = '0;
    ramWr    = 1'b0;
    ramDout  = 8'd0;
    memWd    = NOPRegAddr;
    memWreg  = 1'b0;
    memWdata = ZeroWord;
    haltType = HaltNone;
    stallReq = 1'b0;
    case (state_q)
      StIdle: begin
        if (isMemOp(bus.ex_mem_op)) begin
          haltType = HaltBubble;
          stallReq = 1'b1;
        end else begin
          memWd    = bus.ex_wd;
          memWreg  = bus.ex_wreg;
          memWdata = bus.ex_wdata;
        end
      end
      StAccess: begin
        haltType = HaltBubble;
        stallReq = 1'b1;
        if (isStore(op_q)) begin
          ramAddr = curAddr;
          ramWr   = 1'b1;
          ramDout = sdata_q[{idx_q[1:0], 3'b000} +: 8];
        end else if (idx_q < nBytes) begin
          ramAddr = curAddr;
        end
      end
      StDone: begin
        memWd = wd_q;
        if (!isStore(op_q)) begin
          memWreg  = wreg_q;
          memWdata = loadResult;
        end
`ifdef MISALIGN_TRAP_EN
        if (misalign_q) begin
          memWreg  = 1'b0;
          memWdata = ZeroWord;
        end
`endif
      end
      default: ;
    endcase
  end

  assign bus.ram_addr  = ramAddr;
  assign bus.ram_wr    = ramWr;
  assign bus.ram_dout  = ramDout;
  assign bus.mem_wd    = memWd;
  assign bus.mem_wreg  = memWreg;
  assign bus.mem_wdata = memWdata;
  assign bus.halt_type = haltType;
  assign bus.stall_req = stallReq;
`ifdef MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a byte-wide synchronous RAM model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   nChecks;
  int   nFails;

  always #5 clk = ~clk;

  mem_stage_if bus ();
`ifdef MISALIGN_TRAP_EN
  logic misalign;
`endif

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign (misalign)
`endif
  );

  logic [7:0] ram [0:(1<<RAM_AW)-1];

  // Read data appears one cycle after the address; writes land on the same edge.
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [4:0] wd,
                               input logic wreg, input logic [31:0] wdata);
    bus.ex_mem_op     = op;
    bus.ex_mem_addr   = addr;
    bus.ex_store_data = sdata;
    bus.ex_wd         = wd;
    bus.ex_wreg       = wreg;
    bus.ex_wdata      = wdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic stall, input logic [1:0] halt,
                             input logic wr);
    checkOutput({tag, "_stall"}, 32'(bus.stall_req), 32'(stall));
    checkOutput({tag, "_halt"},  32'(bus.halt_type), 32'(halt));
    checkOutput({tag, "_ramwr"}, 32'(bus.ram_wr),    32'(wr));
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst     = 1'b0;
    for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 8'h00;
    ram[17'h00100] = 8'h78; ram[17'h00101] = 8'h56;
    ram[17'h00102] = 8'h34; ram[17'h00103] = 8'h12;
    ram[17'h00010] = 8'h80;
    ram[17'h00202] = 8'h5A;
    ram[17'h1FFFE] = 8'h11; ram[17'h1FFFF] = 8'h22;
    ram[17'h00000] = 8'h33; ram[17'h00001] = 8'h44;
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    checkOutput("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
    checkStatus("rst", 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] pass-through");
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF);
    checkOutput("pt_wd",    32'(bus.mem_wd),   32'd5);
    checkOutput("pt_wreg",  32'(bus.mem_wreg), 32'd1);
    checkOutput("pt_wdata", bus.mem_wdata,     32'hDEADBEEF);
    checkStatus("pt", 1'b0, 2'b00, 1'b0);
    applyStimulus(4'd12, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0BADF00D);
    checkOutput("op12_wdata", bus.mem_wdata, 32'h0BADF00D);
    checkStatus("op12", 1'b0, 2'b00, 1'b0);
    tick();
    checkOutput("op12_next_stall", 32'(bus.stall_req), 32'd0);

    $display("[TB] LW 0x100");
    applyStimulus(MemOpLW, 32'h100, 32'h0, 5'd7, 1'b1, 32'h11111111);
    checkStatus("lw_t0", 1'b1, 2'b11, 1'b0);
    checkOutput("lw_t0_wreg", 32'(bus.mem_wreg), 32'd0);
    tick();
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    checkOutput("lw_t1_addr", 32'(bus.ram_addr), 32'h100);
    checkStatus("lw_t1", 1'b1, 2'b11, 1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("lw_tk_addr", 32'(bus.ram_addr), 32'h100 + 32'(k));
      checkOutput("lw_tk_stall", 32'(bus.stall_req), 32'd1);
    end
    tick();
    checkStatus("lw_t5", 1'b1, 2'b11, 1'b0);
    tick();
    checkStatus("lw_t6", 1'b0, 2'b00, 1'b0);
    checkOutput("lw_t6_wreg",  32'(bus.mem_wreg), 32'd1);
    checkOutput("lw_t6_wd",    32'(bus.mem_wd),   32'd7);
    checkOutput("lw_t6_wdata", bus.mem_wdata,     32'h12345678);
    tick();
    checkStatus("lw_after", 1'b0, 2'b00, 1'b0);

    $display("[TB] SH 0x200");
    applyStimulus(MemOpSH, 32'h200, 32'hAABBCCDD, 5'd9, 1'b1, 32'h0);
    checkStatus("sh_t0", 1'b1, 2'b11, 1'b0);
    tick();
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    checkStatus("sh_t1", 1'b1, 2'b11, 1'b1);
    checkOutput("sh_t1_addr", 32'(bus.ram_addr), 32'h200);
    checkOutput("sh_t1_dout", 32'(bus.ram_dout), 32'hDD);
    tick();
    checkStatus("sh_t2", 1'b1, 2'b11, 1'b1);
    checkOutput("sh_t2_addr", 32'(bus.ram_addr), 32'h201);
    checkOutput("sh_t2_dout", 32'(bus.ram_dout), 32'hCC);
    tick();
    checkStatus("sh_t3", 1'b0, 2'b00, 1'b0);
    checkOutput("sh_t3_wreg",  32'(bus.mem_wreg), 32'd0);
    checkOutput("sh_t3_wdata", bus.mem_wdata,     32'h0);
    tick();
    checkOutput("sh_ram200", 32'(ram[17'h00200]), 32'hDD);
    checkOutput("sh_ram201", 32'(ram[17'h00201]), 32'hCC);
    checkOutput("sh_ram202", 32'(ram[17'h00202]), 32'h5A);

    $display("[TB] LB / LBU 0x10");
    applyStimulus(MemOpLB, 32'h10, 32'h0, 5'd10, 1'b1, 32'h0);
    tick();
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    checkOutput("lb_t1_addr", 32'(bus.ram_addr), 32'h10);
    tick();
    checkOutput("lb_t2_stall", 32'(bus.stall_req), 32'd1);
    tick();
    checkStatus("lb_t3", 1'b0, 2'b00, 1'b0);
    checkOutput("lb_t3_wdata", bus.mem_wdata, 32'hFFFFFF80);
    checkOutput("lb_t3_wd",    32'(bus.mem_wd), 32'd10);
    tick();
    applyStimulus(MemOpLBU, 32'h10, 32'h0, 5'd11, 1'b1, 32'h0);
    tick();
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();
    tick();
    checkStatus("lbu_t3", 1'b0, 2'b00, 1'b0);
    checkOutput("lbu_t3_wdata", bus.mem_wdata, 32'h00000080);
    checkOutput("lbu_t3_wreg",  32'(bus.mem_wreg), 32'd1);
    tick();

    $display("[TB] LW 0x1FFFE");
    applyStimulus(MemOpLW, 32'h1FFFE, 32'h0, 5'd12, 1'b1, 32'h0);
    checkOutput("wrap_t0_stall", 32'(bus.stall_req), 32'd1);
    tick();
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("wrap_t1_misalign", 32'(misalign), 32'd1);
    checkStatus("wrap_t1", 1'b0, 2'b00, 1'b0);
    checkOutput("wrap_t1_wreg", 32'(bus.mem_wreg), 32'd0);
    tick();
    checkOutput("wrap_t2_misalign", 32'(misalign), 32'd0);
    checkOutput("wrap_t2_stall", 32'(bus.stall_req), 32'd0);
`else
    checkOutput("wrap_t1_addr", 32'(bus.ram_addr), 32'h1FFFE);
    tick();
    checkOutput("wrap_t2_addr", 32'(bus.ram_addr), 32'h1FFFF);
    tick();
    checkOutput("wrap_t3_addr", 32'(bus.ram_addr), 32'h00000);
    tick();
    checkOutput("wrap_t4_addr", 32'(bus.ram_addr), 32'h00001);
    tick();
    tick();
    checkStatus("wrap_t6", 1'b0, 2'b00, 1'b0);
    checkOutput("wrap_t6_wdata", bus.mem_wdata, 32'h44332211);
    tick();
`endif

    $display("[TB] reset during SW");
    applyStimulus(MemOpSW, 32'h300, 32'h01020304, 5'd13, 1'b0, 32'h0);
    tick();
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    checkOutput("sw_t1_dout", 32'(bus.ram_dout), 32'h04);
    tick();
    checkOutput("sw_t2_wr",   32'(bus.ram_wr),   32'd1);
    checkOutput("sw_t2_addr", 32'(bus.ram_addr), 32'h301);
    rst = 1'b1;
    #1;
    checkStatus("sw_rst", 1'b0, 2'b00, 1'b0);
    checkOutput("sw_rst_addr", 32'(bus.ram_addr), 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(MemOpNone, 32'h0, 32'h0, 5'd3, 1'b1, 32'hCAFEF00D);
    checkStatus("post_rst", 1'b0, 2'b00, 1'b0);
    checkOutput("post_rst_wdata", bus.mem_wdata, 32'hCAFEF00D);
    checkOutput("post_rst_wreg",  32'(bus.mem_wreg), 32'd1);
    checkOutput("sw_ram300", 32'(ram[17'h00300]), 32'h04);
    checkOutput("sw_ram301", 32'(ram[17'h00301]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
